// File: rtl/instr_sequencer.sv
// Fetch/execute control FSM driving the 12-bit PC, instruction/operand registers and execute strobe.
// Optional feature: define SINGLE_STEP_EN to add a `step` input that releases one instruction per rising edge.
module instr_sequencer #(
   parameter int         BOOT_CYCLES = 2,
   parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic        run,
   input  logic        mem_ready,
   input  logic [7:0]  prog_byte,
   input  logic        flag_c,
   input  logic        flag_z,
   output logic        pc_enable,
   output logic        pc_load,
   output logic [11:0] pc_bload,
   output logic [7:0]  ir_q,
   output logic [7:0]  operand_q,
   output logic        exec_strobe,
   output logic        halted,
   output logic [2:0]  state_o
);

   localparam logic [2:0] S_BOOT   = 3'd0;
   localparam logic [2:0] S_FETCH1 = 3'd1;
   localparam logic [2:0] S_FETCH2 = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam int CW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

   logic [2:0]    state;
   logic [2:0]    state_next;
   logic [CW-1:0] boot_cnt;
   logic          take_q;
   logic          exec_q;
   logic          start_ok;
   logic          fetch1_accept;
   logic          fetch2_accept;
   logic          byte_is_halt;
   logic          byte_is_two;
   logic          take;

`ifdef SINGLE_STEP_EN
   logic step_q;
   logic pending;

   // A registered rising edge on step arms one instruction; a new edge wins over the accept clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_q  <= 1'b0;
         pending <= 1'b0;
      end else begin
         step_q <= step;
         if (step && !step_q)
            pending <= 1'b1;
         else if (fetch1_accept)
            pending <= 1'b0;
      end
   end

   assign start_ok = run | pending;
`else
   assign start_ok = run;
`endif

   assign fetch1_accept = (state == S_FETCH1) && start_ok && mem_ready;
   assign fetch2_accept = (state == S_FETCH2) && mem_ready;
   assign pc_enable     = fetch1_accept | fetch2_accept;

   assign byte_is_halt = (prog_byte == HALT_OPCODE);
   assign byte_is_two  = (prog_byte[7:4] == 4'hC) || (prog_byte[7:4] == 4'hD) ||
                         (prog_byte[7:4] == 4'hE);

   // Jump decision uses flags only in the cycle the operand byte is accepted.
   assign take = (ir_q[7:4] == 4'hE) ||
                 ((ir_q[7:4] == 4'hC) && flag_c) ||
                 ((ir_q[7:4] == 4'hD) && flag_z);

   always_comb begin
      state_next = state;
      case (state)
         S_BOOT: begin
            if (boot_cnt <= CW'(1))
               state_next = S_FETCH1;
         end
         S_FETCH1: begin
            if (fetch1_accept) begin
               if (byte_is_halt)
                  state_next = S_HALT;
               else if (byte_is_two)
                  state_next = S_FETCH2;
               else
                  state_next = S_EXEC;
            end
         end
         S_FETCH2: begin
            if (fetch2_accept)
               state_next = S_EXEC;
         end
         S_EXEC:  state_next = S_FETCH1;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_BOOT;
         boot_cnt <= CW'(BOOT_CYCLES);
      end else begin
         state <= state_next;
         if (state == S_BOOT && boot_cnt != '0)
            boot_cnt <= boot_cnt - 1'b1;
      end
   end

   // pc_load and exec_strobe are flops so the PC sees clean one-cycle pulses during EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q      <= 8'h00;
         operand_q <= 8'h00;
         pc_bload  <= 12'h000;
         take_q    <= 1'b0;
         exec_q    <= 1'b0;
      end else begin
         if (fetch1_accept)
            ir_q <= prog_byte;
         if (fetch2_accept) begin
            operand_q <= prog_byte;
            pc_bload  <= {ir_q[3:0], prog_byte};
         end
         take_q <= fetch2_accept && take;
         exec_q <= fetch1_accept && !byte_is_halt && !byte_is_two;
      end
   end

   assign pc_load     = take_q;
   assign exec_strobe = exec_q;
   assign halted      = (state == S_HALT);
   assign state_o     = state;

endmodule
